// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Shares one DDR controller native command interface between NUM_PORTS requesters.
// Write and read paths are arbitrated independently and round-robin. Each grant is held
// until the owner drops its request. A tag FIFO records the issuing port of every read
// address, so returning read beats are steered back to their requester in order.
//
// Ports
//   aclk_i / aresetn_i            clock, asynchronous active-low reset
//   p_wr_*_i / p_wr_*_o           per-port write request, strobe, address, data, mask, busy, ack
//   p_rd_*_i / p_rd_*_o           per-port read request, address strobe, address, busy, data,
//                                 valid, ack
//   wr_busy_i .. rd_data_i        DDR controller status and read data
//   wr_en_o .. wr_datamask_o      DDR controller write command
//   rd_en_o .. rd_addr_o          DDR controller read command
//   rd_orphan_err_o               sticky: read beat returned with no outstanding tag
module ddr_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned TAG_FW     = 4
) (
    input  logic                                aclk_i,
    input  logic                                aresetn_i,
    // requester write side
    input  logic [NUM_PORTS-1:0]                p_wr_req_i,
    input  logic [NUM_PORTS-1:0]                p_wr_en_i,
    input  logic [NUM_PORTS*32-1:0]             p_wr_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     p_wr_data_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   p_wr_datamask_i,
    output logic [NUM_PORTS-1:0]                p_wr_busy_o,
    output logic [NUM_PORTS-1:0]                p_wr_ack_o,
    // requester read side
    input  logic [NUM_PORTS-1:0]                p_rd_req_i,
    input  logic [NUM_PORTS-1:0]                p_rd_addr_en_i,
    input  logic [NUM_PORTS*32-1:0]             p_rd_addr_i,
    output logic [NUM_PORTS-1:0]                p_rd_busy_o,
    output logic [DATA_WIDTH-1:0]               p_rd_data_o,
    output logic [NUM_PORTS-1:0]                p_rd_valid_o,
    output logic [NUM_PORTS-1:0]                p_rd_ack_o,
    // DDR controller status / data
    input  logic                                wr_busy_i,
    input  logic                                wr_ack_i,
    input  logic                                rd_busy_i,
    input  logic                                rd_ack_i,
    input  logic                                rd_valid_i,
    input  logic [DATA_WIDTH-1:0]               rd_data_i,
    // DDR controller commands
    output logic                                wr_en_o,
    output logic                                wr_addr_en_o,
    output logic [31:0]                         wr_addr_o,
    output logic [DATA_WIDTH-1:0]               wr_data_o,
    output logic [DATA_WIDTH/8-1:0]             wr_datamask_o,
    output logic                                rd_en_o,
    output logic                                rd_addr_en_o,
    output logic [31:0]                         rd_addr_o,
    output logic                                rd_orphan_err_o
);

    localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned MaskW    = DATA_WIDTH / 8;
    localparam int unsigned TagDepth = 1 << TAG_FW;

    typedef enum logic [0:0] {StIdle, StGrant} arb_state_e;

    // First requester at or after ptr, wrapping; only called when some request is set.
    function automatic logic [PortW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PortW-1:0]     ptr);
        logic [PortW-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                pick  = PortW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PortW-1:0] rr_next(input logic [PortW-1:0] g);
        return (int'(g) == NUM_PORTS - 1) ? '0 : g + PortW'(1);
    endfunction

    // ------------------------------------------------------------------------------------
    // Write arbiter. The grant register holds its value after release, so it doubles as
    // the write owner used to steer wr_ack.
    // ------------------------------------------------------------------------------------
    arb_state_e       w_state_q, w_state_d;
    logic [PortW-1:0] wgnt_q, wgnt_d;
    logic [PortW-1:0] rr_w_q, rr_w_d;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            w_state_q <= StIdle;
            wgnt_q    <= '0;
            rr_w_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            wgnt_q    <= wgnt_d;
            rr_w_q    <= rr_w_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        rr_w_d    = rr_w_q;
        unique case (w_state_q)
            StIdle: begin
                if (|p_wr_req_i) begin
                    wgnt_d    = rr_pick(p_wr_req_i, rr_w_q);
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                if (!p_wr_req_i[wgnt_q]) begin
                    w_state_d = StIdle;
                    rr_w_d    = rr_next(wgnt_q);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_en_o       = 1'b0;
        wr_addr_en_o  = 1'b0;
        wr_addr_o     = '0;
        wr_data_o     = '0;
        wr_datamask_o = '0;
        p_wr_busy_o   = '1;
        p_wr_ack_o    = '0;
        p_wr_ack_o[wgnt_q] = wr_ack_i;
        if (w_state_q == StGrant) begin
            wr_en_o              = p_wr_en_i[wgnt_q] & ~wr_busy_i;
            wr_addr_en_o         = wr_en_o;
            wr_addr_o            = p_wr_addr_i[int'(wgnt_q)*32 +: 32];
            wr_data_o            = p_wr_data_i[int'(wgnt_q)*DATA_WIDTH +: DATA_WIDTH];
            wr_datamask_o        = p_wr_datamask_i[int'(wgnt_q)*MaskW +: MaskW];
            p_wr_busy_o[wgnt_q]  = wr_busy_i;
        end
    end

    // ------------------------------------------------------------------------------------
    // Read arbiter, same structure; rgnt_q is also the read owner.
    // ------------------------------------------------------------------------------------
    arb_state_e       r_state_q, r_state_d;
    logic [PortW-1:0] rgnt_q, rgnt_d;
    logic [PortW-1:0] rr_r_q, rr_r_d;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_state_q <= StIdle;
            rgnt_q    <= '0;
            rr_r_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            rgnt_q    <= rgnt_d;
            rr_r_q    <= rr_r_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        rr_r_d    = rr_r_q;
        unique case (r_state_q)
            StIdle: begin
                if (|p_rd_req_i) begin
                    rgnt_d    = rr_pick(p_rd_req_i, rr_r_q);
                    r_state_d = StGrant;
                end
            end
            StGrant: begin
                if (!p_rd_req_i[rgnt_q]) begin
                    r_state_d = StIdle;
                    rr_r_d    = rr_next(rgnt_q);
                end
            end
            default: r_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------------------
    // Read tag FIFO: one entry per issued read address, holding the issuing port.
    // ------------------------------------------------------------------------------------
    logic [PortW-1:0]  tag_mem_q [TagDepth];
    logic [TAG_FW-1:0] tag_wptr_q, tag_rptr_q;
    logic [TAG_FW:0]   tag_cnt_q, tag_cnt_d;
    logic              orphan_q, orphan_d;
    logic              tag_full, tag_empty, tag_push, tag_pop;
    logic [PortW-1:0]  tag_head;

    assign tag_full  = (tag_cnt_q == (TAG_FW+1)'(TagDepth));
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_head  = tag_mem_q[tag_rptr_q];
    assign tag_push  = rd_addr_en_o;
    // A beat arriving with no outstanding tag is dropped rather than misrouted.
    assign tag_pop   = rd_valid_i & ~tag_empty;

    always_comb begin
        unique case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase
        orphan_d = orphan_q | (rd_valid_i & tag_empty);
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < TagDepth; i++) begin
                tag_mem_q[i] <= '0;
            end
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
            tag_cnt_q  <= '0;
            orphan_q   <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_mem_q[tag_wptr_q] <= rgnt_q;
                tag_wptr_q            <= tag_wptr_q + 1'b1;
            end
            if (tag_pop) begin
                tag_rptr_q <= tag_rptr_q + 1'b1;
            end
            tag_cnt_q <= tag_cnt_d;
            orphan_q  <= orphan_d;
        end
    end

    // Read outputs
    always_comb begin
        rd_addr_en_o = 1'b0;
        rd_addr_o    = '0;
        p_rd_busy_o  = '1;
        p_rd_ack_o   = '0;
        p_rd_valid_o = '0;
        p_rd_ack_o[rgnt_q] = rd_ack_i;
        if (r_state_q == StGrant) begin
            // A full FIFO blocks the push even if a pop happens this cycle.
            rd_addr_en_o        = p_rd_addr_en_i[rgnt_q] & ~rd_busy_i & ~tag_full;
            rd_addr_o           = p_rd_addr_i[int'(rgnt_q)*32 +: 32];
            p_rd_busy_o[rgnt_q] = rd_busy_i | tag_full;
        end
        if (tag_pop) begin
            p_rd_valid_o[tag_head] = 1'b1;
        end
    end

    assign p_rd_data_o     = rd_data_i;
    assign rd_en_o         = 1'b1;
    assign rd_orphan_err_o = orphan_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
module tb_ddr_port_arbiter;

    localparam int NP = 2;
    localparam int DW = 128;
    localparam int TFW = 2;
    localparam int TAG_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   p_wr_req, p_wr_en, p_wr_busy, p_wr_ack;
    logic [NP*32-1:0] p_wr_addr, p_rd_addr;
    logic [NP*DW-1:0] p_wr_data;
    logic [NP*DW/8-1:0] p_wr_datamask;
    logic [NP-1:0]   p_rd_req, p_rd_addr_en, p_rd_busy, p_rd_valid, p_rd_ack;
    logic [DW-1:0]   p_rd_data, rd_data, wr_data;
    logic            wr_busy, wr_ack, rd_busy, rd_ack, rd_valid;
    logic            wr_en, wr_addr_en, rd_en, rd_addr_en, rd_orphan_err;
    logic [31:0]     wr_addr, rd_addr;
    logic [DW/8-1:0] wr_datamask;

    ddr_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TAG_FW(TFW)) dut (
        .aclk_i(clk), .aresetn_i(rst_n),
        .p_wr_req_i(p_wr_req), .p_wr_en_i(p_wr_en), .p_wr_addr_i(p_wr_addr),
        .p_wr_data_i(p_wr_data), .p_wr_datamask_i(p_wr_datamask),
        .p_wr_busy_o(p_wr_busy), .p_wr_ack_o(p_wr_ack),
        .p_rd_req_i(p_rd_req), .p_rd_addr_en_i(p_rd_addr_en), .p_rd_addr_i(p_rd_addr),
        .p_rd_busy_o(p_rd_busy), .p_rd_data_o(p_rd_data), .p_rd_valid_o(p_rd_valid),
        .p_rd_ack_o(p_rd_ack),
        .wr_busy_i(wr_busy), .wr_ack_i(wr_ack), .rd_busy_i(rd_busy), .rd_ack_i(rd_ack),
        .rd_valid_i(rd_valid), .rd_data_i(rd_data),
        .wr_en_o(wr_en), .wr_addr_en_o(wr_addr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_datamask_o(wr_datamask), .rd_en_o(rd_en), .rd_addr_en_o(rd_addr_en),
        .rd_addr_o(rd_addr), .rd_orphan_err_o(rd_orphan_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic exp_orphan = 1'b0;

    typedef struct {
        logic [1:0] wen;
        logic       wbusy;
        logic       wack;
        logic       exp_en;
        logic [1:0] exp_busy;
        logic [1:0] exp_ack;
    } wvec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        p_wr_req = '0; p_wr_en = '0; p_wr_addr = '0; p_wr_data = '0; p_wr_datamask = '0;
        p_rd_req = '0; p_rd_addr_en = '0; p_rd_addr = '0;
        wr_busy = 0; wr_ack = 0; rd_busy = 0; rd_ack = 0; rd_valid = 0; rd_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr_en", wr_addr_en, 0);
        chk("rst_rd_addr_en", rd_addr_en, 0);
        chk("rst_p_wr_busy", p_wr_busy, 2'b11);
        chk("rst_p_rd_busy", p_rd_busy, 2'b11);
        chk("rst_p_rd_valid", p_rd_valid, 0);
        chk("rst_orphan", rd_orphan_err, 0);
        chk("rst_rd_en", rd_en, 1);
        chk("rst_p_wr_ack", p_wr_ack, 0);
        chk("rst_p_rd_ack", p_rd_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_orphan = 1'b0;
    endtask

    // Issue n read addresses from port p; acceptance is predicted from the tag model.
    task automatic rd_issue(input int p, input int n);
        logic       acc;
        logic [1:0] exp_busy;
        logic [31:0] a;
        @(negedge clk);
        p_rd_req[p] = 1'b1;
        #2;
        chk("rd_arb_latency", rd_addr_en, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a = 32'h8000_0000 + (p << 16) + i * 64;
            p_rd_addr_en[p] = 1'b1;
            p_rd_addr[p*32 +: 32] = a;
            #2;
            acc = (exp_q.size() < TAG_DEPTH);
            exp_busy = 2'b11;
            exp_busy[p] = ~acc;
            chk("rd_issue_en", rd_addr_en, acc);
            chk("rd_issue_addr", rd_addr, a);
            chk("rd_issue_busy", p_rd_busy, exp_busy);
            if (acc) exp_q.push_back(p);
        end
        @(negedge clk);
        p_rd_addr_en = '0;
        p_rd_req = '0;
    endtask

    task automatic rd_return();
        logic [1:0] exp_v;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        #2;
        exp_v = '0;
        if (exp_q.size() == 0) exp_orphan = 1'b1;
        else exp_v[exp_q.pop_front()] = 1'b1;
        chk("rd_ret_valid", p_rd_valid, exp_v);
        chk("rd_ret_data", p_rd_data, rd_data);
        @(negedge clk);
        rd_valid = 1'b0;
        #2;
        chk("rd_ret_orphan", rd_orphan_err, exp_orphan);
    endtask

    initial begin
        wvec_t wtab[7];
        int pulses;
        logic [31:0] a0;
        logic [DW-1:0] d0;
        logic [DW/8-1:0] m0;

        wtab[0] = '{2'b01, 0, 0, 1, 2'b10, 2'b00};
        wtab[1] = '{2'b11, 0, 0, 1, 2'b10, 2'b00};
        wtab[2] = '{2'b00, 1, 0, 0, 2'b11, 2'b00};
        wtab[3] = '{2'b01, 1, 0, 0, 2'b11, 2'b00};
        wtab[4] = '{2'b01, 0, 1, 1, 2'b10, 2'b01};
        wtab[5] = '{2'b01, 0, 0, 1, 2'b10, 2'b00};
        wtab[6] = '{2'b10, 0, 1, 0, 2'b10, 2'b01};

        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // Single-port write burst, table driven
        @(negedge clk);
        p_wr_req = 2'b01;
        #2;
        chk("w_arb_latency", p_wr_busy, 2'b11);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a0 = 32'h1000 + i * 16;
            d0 = {4{32'h0000_00a0 + i}};
            m0 = 16'h00ff ^ 16'(i);
            p_wr_addr = {32'hdead_0000, a0};
            p_wr_data = {{4{32'hffff_ffff}}, d0};
            p_wr_datamask = {16'hffff, m0};
            p_wr_en = wtab[i].wen;
            wr_busy = wtab[i].wbusy;
            wr_ack = wtab[i].wack;
            #2;
            chk("w_tab_en", wr_en, wtab[i].exp_en);
            chk("w_tab_addr_en", wr_addr_en, wtab[i].exp_en);
            chk("w_tab_busy", p_wr_busy, wtab[i].exp_busy);
            chk("w_tab_ack", p_wr_ack, wtab[i].exp_ack);
            chk("w_tab_addr", wr_addr, a0);
            chk("w_tab_data", wr_data, d0);
            chk("w_tab_mask", wr_datamask, m0);
            if (wr_en) pulses++;
        end
        chk("w_pulse_count", pulses, 4);
        @(negedge clk);
        p_wr_req = 0; p_wr_en = 0; wr_ack = 0; wr_busy = 0;
        @(negedge clk);
        p_wr_en = 2'b11; wr_ack = 1;
        #2;
        chk("w_release_en", wr_en, 0);
        chk("w_release_busy", p_wr_busy, 2'b11);
        chk("w_owner_held_ack", p_wr_ack, 2'b01);
        @(negedge clk);
        p_wr_en = 0; wr_ack = 0;

        // Write contention and round-robin
        do_reset();
        @(negedge clk);
        p_wr_addr = {32'h200, 32'h100};
        p_wr_req = 2'b11; p_wr_en = 2'b11;
        #2;
        chk("cont_idle", p_wr_busy, 2'b11);
        @(negedge clk); #2;
        chk("cont_p0_first", p_wr_busy, 2'b10);
        chk("cont_p0_addr", wr_addr, 32'h100);
        @(negedge clk);
        p_wr_req = 2'b10;
        #2;
        chk("cont_p0_hold", p_wr_busy, 2'b10);
        @(negedge clk); #2;
        chk("cont_gap_busy", p_wr_busy, 2'b11);
        chk("cont_gap_en", wr_en, 0);
        @(negedge clk); #2;
        chk("cont_p1_grant", p_wr_busy, 2'b01);
        chk("cont_p1_addr", wr_addr, 32'h200);
        @(negedge clk);
        wr_ack = 1;
        #2;
        chk("cont_p1_ack", p_wr_ack, 2'b10);
        @(negedge clk);
        wr_ack = 0; p_wr_req = 2'b01;
        @(negedge clk);
        p_wr_req = 2'b11;
        #2;
        chk("cont_gap2", p_wr_busy, 2'b11);
        @(negedge clk); #2;
        chk("cont_p0_again", p_wr_busy, 2'b10);
        @(negedge clk);
        p_wr_req = 0; p_wr_en = 0;

        // Interleaved reads, steered back by tag
        do_reset();
        rd_issue(0, 3);
        rd_return();
        rd_issue(1, 2);
        @(negedge clk);
        rd_ack = 1;
        #2;
        chk("rd_ack_owner", p_rd_ack, 2'b10);
        @(negedge clk);
        rd_ack = 0;
        repeat (4) rd_return();

        // Tag FIFO full
        @(negedge clk);
        p_rd_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p_rd_addr_en = 2'b01;
            p_rd_addr[31:0] = 32'h4000 + i;
            #2;
            chk("full_fill_en", rd_addr_en, 1);
            exp_q.push_back(0);
        end
        @(negedge clk);
        p_rd_addr[31:0] = 32'h4004;
        #2;
        chk("full_block_en", rd_addr_en, 0);
        chk("full_block_busy", p_rd_busy, 2'b11);
        @(negedge clk);
        rd_valid = 1;
        #2;
        chk("full_pop_still_blocks", rd_addr_en, 0);
        chk("full_pop_valid", p_rd_valid, 2'b01);
        void'(exp_q.pop_front());
        @(negedge clk);
        rd_valid = 0;
        #2;
        chk("full_slot_freed", rd_addr_en, 1);
        exp_q.push_back(0);
        @(negedge clk); #2;
        chk("full_one_slot_only", rd_addr_en, 0);
        @(negedge clk);
        p_rd_addr_en = 0; p_rd_req = 0;
        repeat (4) rd_return();

        // rd_busy stall, single push
        @(negedge clk);
        p_rd_req = 2'b01;
        @(negedge clk);
        p_rd_addr_en = 2'b01; p_rd_addr[31:0] = 32'h7777_0040; rd_busy = 1;
        #2;
        chk("stall_en", rd_addr_en, 0);
        chk("stall_busy", p_rd_busy, 2'b11);
        chk("stall_addr", rd_addr, 32'h7777_0040);
        @(negedge clk); #2;
        chk("stall_en2", rd_addr_en, 0);
        @(negedge clk);
        rd_busy = 0;
        #2;
        chk("stall_issue", rd_addr_en, 1);
        exp_q.push_back(0);
        @(negedge clk);
        p_rd_addr_en = 0; p_rd_req = 0;
        #2;
        chk("stall_no_repeat", rd_addr_en, 0);
        @(negedge clk);
        rd_ack = 1;
        #2;
        chk("rd_ack_p0", p_rd_ack, 2'b01);
        @(negedge clk);
        rd_ack = 0;
        rd_return();
        rd_return();   // no tag left: orphan
        repeat (3) @(negedge clk);
        #2;
        chk("orphan_sticky", rd_orphan_err, 1);
        do_reset();

        // In-flight read across reset becomes an orphan
        rd_issue(0, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        exp_orphan = 0;
        rd_return();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
